// File: rtl/des_pkg.sv
// Shared constants and FSM state encoding for the DES host loader and its byte shifters.
package des_pkg;

  localparam int unsigned BYTES_PER_BLOCK = 8;

  localparam logic [5:0] PT_ADDR_DEFAULT = 6'd0;
  localparam logic [5:0] CT_ADDR_DEFAULT = 6'd1;

  localparam logic [2:0] ST_RX_ENC        = 3'd0;
  localparam logic [2:0] ST_WR_PT_ENC     = 3'd1;
  localparam logic [2:0] ST_KICK_ENC      = 3'd2;
  localparam logic [2:0] ST_WAIT_CTRL_ENC = 3'd3;
  localparam logic [2:0] ST_RD_CT_ENC     = 3'd4;
  localparam logic [2:0] ST_WAIT_RD_ENC   = 3'd5;
  localparam logic [2:0] ST_CAPTURE_ENC   = 3'd6;
  localparam logic [2:0] ST_TX_ENC        = 3'd7;

  typedef enum logic [2:0] {
    StRx       = ST_RX_ENC,
    StWrPt     = ST_WR_PT_ENC,
    StKick     = ST_KICK_ENC,
    StWaitCtrl = ST_WAIT_CTRL_ENC,
    StRdCt     = ST_RD_CT_ENC,
    StWaitRd   = ST_WAIT_RD_ENC,
    StCapture  = ST_CAPTURE_ENC,
    StTx       = ST_TX_ENC
  } loader_state_e;

endpackage

// File: rtl/des_byte_shifter.sv
// 64-bit register that loads in parallel or shifts one byte in at the LSB end,
// with a 3-bit byte counter that wraps after a full block.
module des_byte_shifter
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [63:0] i_load_data,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [63:0] o_word,
  output logic [7:0]  o_top_byte,
  output logic        o_last
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_BLOCK - 1);

  logic [63:0] r_word;
  logic [2:0]  r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[55:0], i_byte};
      r_cnt  <= r_cnt + 3'd1;
    end
  end

  assign o_word     = r_word;
  assign o_top_byte = r_word[63:56];
  // Asserted on the shift that completes a block; the counter wraps to 0 on that same edge.
  assign o_last     = i_shift && (r_cnt == LAST_IDX);

endmodule

// File: rtl/des_host_loader.sv
// Byte-stream front end for the DES BRAM controller: assembles a plaintext block, kicks the
// controller, reads back the ciphertext and streams it out. DES_HOST_TIMEOUT_EN adds a WAIT_CTRL timeout.
module des_host_loader
  import des_pkg::*;
#(
  parameter logic [5:0]  PT_ADDR        = PT_ADDR_DEFAULT,
  parameter logic [5:0]  CT_ADDR        = CT_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_bram_sel,
  output logic [5:0]  o_bram_addr,
  output logic [63:0] o_bram_din,
  output logic        o_bram_we,
  output logic        o_bram_en,
  input  logic [63:0] i_bram_dout,
  output logic        o_ctrl_start,
  output logic        o_ctrl_rst,
  input  logic        i_ctrl_done_all,
  output logic        o_busy,
  output logic        o_timeout_err
);

  loader_state_e r_state, w_state_next;

  logic        r_live;
  logic        w_rx_fire, w_tx_fire;
  logic        w_rx_last, w_tx_last;
  logic        w_capture;
  logic        w_timeout;
  logic        w_wait_expired;
  logic        w_to_pulse;
  logic [63:0] w_rx_word;
  logic [7:0]  w_unused_rx_byte;
  logic [63:0] w_unused_tx_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StRx;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
    end
  end

  // r_live keeps rx_ready low while reset is held and raises it on the first clock after release.
  assign o_rx_ready = (r_state == StRx) && r_live;
  assign o_tx_valid = (r_state == StTx);
  assign o_busy     = (r_state != StRx);
  assign w_rx_fire  = i_rx_valid && o_rx_ready;
  assign w_tx_fire  = o_tx_valid && i_tx_ready;
  assign o_ctrl_rst = w_capture || w_to_pulse;

  always_comb begin
    w_state_next = r_state;
    o_bram_sel   = 1'b0;
    o_bram_addr  = '0;
    o_bram_din   = '0;
    o_bram_we    = 1'b0;
    o_bram_en    = 1'b0;
    o_ctrl_start = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      StRx: begin
        if (w_rx_last) w_state_next = StWrPt;
      end
      StWrPt: begin
        o_bram_sel   = 1'b1;
        o_bram_we    = 1'b1;
        o_bram_addr  = PT_ADDR;
        o_bram_din   = w_rx_word;
        w_state_next = StKick;
      end
      StKick: begin
        o_ctrl_start = 1'b1;
        w_state_next = StWaitCtrl;
      end
      StWaitCtrl: begin
        // A done arriving in the final allowed cycle still wins over the timeout.
        if (i_ctrl_done_all) begin
          w_state_next = StRdCt;
        end else if (w_wait_expired) begin
          w_timeout    = 1'b1;
          w_state_next = StRx;
        end
      end
      StRdCt: begin
        o_bram_sel   = 1'b1;
        o_bram_en    = 1'b1;
        o_bram_addr  = CT_ADDR;
        w_state_next = StWaitRd;
      end
      StWaitRd: begin
        o_bram_sel   = 1'b1;
        o_bram_addr  = CT_ADDR;
        w_state_next = StCapture;
      end
      StCapture: begin
        o_bram_sel   = 1'b1;
        o_bram_addr  = CT_ADDR;
        w_capture    = 1'b1;
        w_state_next = StTx;
      end
      StTx: begin
        if (w_tx_last) w_state_next = StRx;
      end
      default: w_state_next = StRx;
    endcase
  end

  des_byte_shifter u_rx_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (1'b0),
    .i_load_data (64'h0),
    .i_shift     (w_rx_fire),
    .i_byte      (i_rx_data),
    .o_word      (w_rx_word),
    .o_top_byte  (w_unused_rx_byte),
    .o_last      (w_rx_last)
  );

  des_byte_shifter u_tx_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_capture),
    .i_load_data (i_bram_dout),
    .i_shift     (w_tx_fire),
    .i_byte      (8'h00),
    .o_word      (w_unused_tx_word),
    .o_top_byte  (o_tx_data),
    .o_last      (w_tx_last)
  );

`ifdef DES_HOST_TIMEOUT_EN
  localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout  <= w_timeout;
      r_wait_cnt <= (r_state == StWaitCtrl) ? r_wait_cnt + 1'b1 : '0;
    end
  end

  // Counter holds TO_LAST during the last permitted WAIT_CTRL cycle; the pulse follows it.
  assign w_wait_expired = (r_wait_cnt == TO_LAST);
  assign w_to_pulse     = r_timeout;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = w_timeout ^ (TIMEOUT_CYCLES != 0);
  assign w_wait_expired   = 1'b0;
  assign w_to_pulse       = 1'b0;
`endif

  assign o_timeout_err = w_to_pulse;

endmodule

// File: tb/tb_des_host_loader.sv
// Self-checking bench for des_host_loader: table-driven frames, a tx scoreboard queue,
// and hand-written reset / timeout sequences.
module tb_des_host_loader;

  localparam logic [5:0] PT_A = 6'd0;
  localparam logic [5:0] CT_A = 6'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_bram_sel;
  logic [5:0]  o_bram_addr;
  logic [63:0] o_bram_din;
  logic        o_bram_we;
  logic        o_bram_en;
  logic [63:0] i_bram_dout;
  logic        o_ctrl_start;
  logic        o_ctrl_rst;
  logic        i_ctrl_done_all;
  logic        o_busy;
  logic        o_timeout_err;

  always #5 clk = ~clk;

  des_host_loader #(
    .PT_ADDR        (PT_A),
    .CT_ADDR        (CT_A),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .o_rx_ready      (o_rx_ready),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready),
    .o_bram_sel      (o_bram_sel),
    .o_bram_addr     (o_bram_addr),
    .o_bram_din      (o_bram_din),
    .o_bram_we       (o_bram_we),
    .o_bram_en       (o_bram_en),
    .i_bram_dout     (i_bram_dout),
    .o_ctrl_start    (o_ctrl_start),
    .o_ctrl_rst      (o_ctrl_rst),
    .i_ctrl_done_all (i_ctrl_done_all),
    .o_busy          (o_busy),
    .o_timeout_err   (o_timeout_err)
  );

  // BRAM + controller model: the ciphertext word is served from ct_model at CT_A.
  logic [63:0] mem [64];
  logic [63:0] ct_model;

  always @(posedge clk) begin
    if (o_bram_sel && o_bram_we) mem[o_bram_addr] <= o_bram_din;
    if (o_bram_sel && o_bram_en) i_bram_dout <= (o_bram_addr == CT_A) ? ct_model : mem[o_bram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pt;
    logic [63:0] ct;
    int          stall_byte;  // 8 = no stall
    int          stall_len;
    bit          spam;        // keep rx_valid high while busy
    int          delay;       // WAIT_CTRL cycles before done
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  int wr_cnt = 0, start_cnt = 0, rst_cnt = 0, to_cnt = 0, rx_cnt = 0, tx_cnt = 0;
  int start_cyc, rst_cyc, to_cyc, done_cyc, rx_cyc, first_tx_cyc;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic        to_with_rst;
  logic        prev_tx_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (o_bram_sel && o_bram_we) begin
        wr_cnt++;
        wr_addr = o_bram_addr;
        wr_data = o_bram_din;
      end
      if (o_ctrl_start) begin start_cnt++; start_cyc = cyc; end
      if (o_ctrl_rst) begin rst_cnt++; rst_cyc = cyc; end
      if (o_timeout_err) begin to_cnt++; to_cyc = cyc; to_with_rst = o_ctrl_rst; end
      if (i_ctrl_done_all) done_cyc = cyc;
      if (i_rx_valid && o_rx_ready) begin rx_cnt++; rx_cyc = cyc; end
      if (o_busy) check("rx_ready_while_busy", o_rx_ready, 0);
      if (o_tx_valid && !prev_tx_valid) first_tx_cyc = cyc;
      if (prev_stall) begin
        check("tx_hold_valid", o_tx_valid, 1);
        check("tx_hold_data", o_tx_data, prev_data);
      end
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_extra_byte: got %0h, expected no byte", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", o_tx_data, e);
        end
        tx_cnt++;
      end
      prev_tx_valid = o_tx_valid;
      prev_stall    = o_tx_valid && !i_tx_ready;
      prev_data     = o_tx_data;
    end
  endtask

  task automatic send_bytes(input logic [63:0] w, input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      i_rx_valid = 1'b1;
      i_rx_data  = w[63-8*i -: 8];
      @(negedge clk);
      while (!o_rx_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      check("rx_ready_in_time", o_rx_ready, 1);
      @(posedge clk); #1;
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_start(input int s_start);
    int g;
    g = 0;
    while (start_cnt == s_start && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("ctrl_start_seen", start_cnt - s_start, 1);
  endtask

  task automatic run_frame(input vec_t v);
    int s_wr, s_start, s_rst, s_rx, s_tx, g, stall_left;
    s_wr = wr_cnt; s_start = start_cnt; s_rst = rst_cnt; s_rx = rx_cnt; s_tx = tx_cnt;
    ct_model = v.ct;
    send_bytes(v.pt, 8);
    if (v.spam) begin
      i_rx_valid = 1'b1;
      i_rx_data  = 8'hA5;
    end
    wait_start(s_start);
    check("bram_write_count", wr_cnt - s_wr, 1);
    check("bram_write_addr", wr_addr, PT_A);
    check("bram_write_data", wr_data, v.pt);
    check("rx_byte_count", rx_cnt - s_rx, 8);
    check("start_latency", start_cyc - rx_cyc, 2);
    repeat (v.delay) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) exp_q.push_back(v.ct[63-8*i -: 8]);
    i_ctrl_done_all = 1'b1;
    @(posedge clk); #1;
    i_ctrl_done_all = 1'b0;
    stall_left = v.stall_len;
    g = 0;
    while (tx_cnt - s_tx < 8 && g < 100) begin
      if (o_tx_valid && (tx_cnt - s_tx) == v.stall_byte && stall_left > 0) begin
        i_tx_ready = 1'b0;
        stall_left--;
        @(negedge clk);
        check("stall_tx_data", o_tx_data, v.ct[63-8*v.stall_byte -: 8]);
        check("stall_tx_valid", o_tx_valid, 1);
      end else begin
        i_tx_ready = 1'b1;
      end
      @(posedge clk); #1;
      g++;
    end
    i_tx_ready = 1'b1;
    check("tx_byte_count", tx_cnt - s_tx, 8);
    check("tx_valid_after_frame", o_tx_valid, 0);
    check("busy_after_frame", o_busy, 0);
    check("done_to_tx_latency", first_tx_cyc - done_cyc, 4);
    check("ctrl_rst_count", rst_cnt - s_rst, 1);
    check("ctrl_rst_before_tx", first_tx_cyc - rst_cyc, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    i_rx_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {o_rx_ready, o_tx_valid, o_tx_data, o_bram_sel, o_bram_addr, o_bram_we,
                 o_bram_en, o_ctrl_start, o_ctrl_rst, o_busy, o_timeout_err}, 0);
    check({name, "_din"}, o_bram_din, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("outputs_in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check("rx_ready_before_first_clock", o_rx_ready, 0);
    @(posedge clk); #1;
    check("rx_ready_after_first_clock", o_rx_ready, 1);
  endtask

  initial begin
    vec_t lv;
    int s_wr, s_start, s_tx, g;

    vecs[0] = '{pt: 64'h0123456789ABCDEF, ct: 64'h85E813540F0AB405, stall_byte: 8,
                stall_len: 0, spam: 1'b0, delay: 3};
    vecs[1] = '{pt: 64'h0123456789ABCDEF, ct: 64'h85E813540F0AB405, stall_byte: 3,
                stall_len: 5, spam: 1'b0, delay: 1};
    vecs[2] = '{pt: 64'hFEDCBA9876543210, ct: 64'h0011223344556677, stall_byte: 8,
                stall_len: 0, spam: 1'b1, delay: 5};
    vecs[3] = '{pt: 64'h8000000000000001, ct: 64'hFF00FF00FF00FF00, stall_byte: 7,
                stall_len: 2, spam: 1'b1, delay: 0};

    reset = 1'b1;
    i_rx_data = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    i_ctrl_done_all = 1'b0;
    ct_model = 64'h0;

    fork
      monitor();
    join_none

    @(posedge clk); #1;
    pulse_reset();

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset mid-rx: the three partial bytes must not leak into the next frame.
    s_wr = wr_cnt; s_start = start_cnt;
    send_bytes(64'hDEADBEEF00000000, 3);
    pulse_reset();
    repeat (4) begin @(posedge clk); #1; end
    check("no_write_after_rx_reset", wr_cnt - s_wr, 0);
    check("no_start_after_rx_reset", start_cnt - s_start, 0);
    run_frame(vecs[2]);

    // Reset while waiting on the controller, then a fresh frame.
    s_wr = wr_cnt; s_start = start_cnt; s_tx = tx_cnt;
    send_bytes(64'h1122334455667788, 8);
    wait_start(s_start);
    repeat (3) begin @(posedge clk); #1; end
    pulse_reset();
    repeat (4) begin @(posedge clk); #1; end
    check("no_tx_after_wait_reset", tx_cnt - s_tx, 0);
    check("single_write_before_wait_reset", wr_cnt - s_wr, 1);
    run_frame(vecs[0]);

`ifdef DES_HOST_TIMEOUT_EN
    s_start = start_cnt; s_tx = tx_cnt;
    lv = vecs[0];
    send_bytes(lv.pt, 8);
    wait_start(s_start);
    g = 0;
    while (to_cnt == 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    check("timeout_pulse_count", to_cnt, 1);
    check("timeout_latency", to_cyc - start_cyc, 17);
    check("timeout_with_ctrl_rst", to_with_rst, 1);
    check("timeout_single_cycle", o_timeout_err, 0);
    check("timeout_busy_cleared", o_busy, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("timeout_no_tx", tx_cnt - s_tx, 0);
    run_frame(vecs[1]);
`else
    lv = vecs[0];
    lv.delay = 40;
    run_frame(lv);
    check("no_timeout_pulse", to_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
